// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Arbitrates a single burst-oriented memory port between the instruction
//   cache (line refills only) and the data cache (refills and write-backs).
//   Each grant moves a full cache line of BURST_LEN beats. Beat addresses step
//   by DATA_W/8 bytes from the latched line base address.
//
// Ports
//   i_riscv_arb_clk / i_riscv_arb_rst   clock, async active-high reset
//   i_riscv_arb_ic_*                    icache request + line address
//   i_riscv_arb_dc_*                    dcache request, direction, address, write word
//   o_riscv_arb_ic_/dc_rvalid, _rdata   read beat return (shared data bus)
//   o_riscv_arb_ic_/dc_done             one-cycle burst-complete pulse
//   o_riscv_arb_dc_beat                 current beat index
//   o_riscv_arb_ic_/dc_stall            request outstanding (to hazard unit)
//   o_riscv_arb_mem_*, i_riscv_arb_mem_* memory-side beat handshake
//
// Configuration
//   RISCV_ARB_ROUND_ROBIN_EN  defined: round-robin between the two caches
//                             (one-bit pointer, updated when a burst finishes).
//                             undefined: dcache has fixed priority.

module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         i_riscv_arb_clk,
    input  logic                         i_riscv_arb_rst,
    input  logic                         i_riscv_arb_ic_req,
    input  logic [ADDR_W-1:0]            i_riscv_arb_ic_addr,
    input  logic                         i_riscv_arb_dc_req,
    input  logic                         i_riscv_arb_dc_we,
    input  logic [ADDR_W-1:0]            i_riscv_arb_dc_addr,
    input  logic [DATA_W-1:0]            i_riscv_arb_dc_wdata,
    output logic                         o_riscv_arb_ic_rvalid,
    output logic                         o_riscv_arb_dc_rvalid,
    output logic [DATA_W-1:0]            o_riscv_arb_rdata,
    output logic                         o_riscv_arb_ic_done,
    output logic                         o_riscv_arb_dc_done,
    output logic [$clog2(BURST_LEN)-1:0] o_riscv_arb_dc_beat,
    output logic                         o_riscv_arb_ic_stall,
    output logic                         o_riscv_arb_dc_stall,
    output logic                         o_riscv_arb_mem_req,
    output logic                         o_riscv_arb_mem_we,
    output logic [ADDR_W-1:0]            o_riscv_arb_mem_addr,
    output logic [DATA_W-1:0]            o_riscv_arb_mem_wdata,
    input  logic                         i_riscv_arb_mem_ack,
    input  logic [DATA_W-1:0]            i_riscv_arb_mem_rdata
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_e;

    state_e              state_q, state_d;
    logic                own_dc_q, own_dc_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                grant_dc;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
    // 1 = dcache favoured on contention
    logic                prio_dc_q, prio_dc_d;

    assign grant_dc = i_riscv_arb_dc_req & (~i_riscv_arb_ic_req | prio_dc_q);

    always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
        if (i_riscv_arb_rst) prio_dc_q <= 1'b1;
        else                 prio_dc_q <= prio_dc_d;
    end

    // Favour whichever requester was not just served.
    always_comb begin
        prio_dc_d = prio_dc_q;
        if (state_q == DONE) prio_dc_d = ~own_dc_q;
    end
`else
    assign grant_dc = i_riscv_arb_dc_req;
`endif

    always_ff @(posedge i_riscv_arb_clk or posedge i_riscv_arb_rst) begin
        if (i_riscv_arb_rst) begin
            state_q  <= IDLE;
            own_dc_q <= 1'b0;
            base_q   <= '0;
            we_q     <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            own_dc_q <= own_dc_d;
            base_q   <= base_d;
            we_q     <= we_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        own_dc_d = own_dc_q;
        base_d   = base_q;
        we_d     = we_q;
        beat_d   = beat_q;
        unique case (state_q)
            IDLE: begin
                if (i_riscv_arb_ic_req | i_riscv_arb_dc_req) begin
                    own_dc_d = grant_dc;
                    base_d   = grant_dc ? i_riscv_arb_dc_addr : i_riscv_arb_ic_addr;
                    we_d     = grant_dc & i_riscv_arb_dc_we;
                    beat_d   = '0;
                    state_d  = grant_dc ? GNT_D : GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (i_riscv_arb_mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic in_gnt;
    logic rd_beat;

    always_comb begin
        in_gnt  = (state_q == GNT_I) | (state_q == GNT_D);
        // we_q is always 0 for an icache grant
        rd_beat = in_gnt & ~we_q;

        o_riscv_arb_mem_req   = in_gnt;
        o_riscv_arb_mem_we    = (state_q == GNT_D) & we_q;
        o_riscv_arb_mem_addr  = in_gnt ? (base_q + ADDR_W'(beat_q) * STRIDE) : '0;
        o_riscv_arb_mem_wdata = o_riscv_arb_mem_we ? i_riscv_arb_dc_wdata : '0;

        o_riscv_arb_rdata     = rd_beat ? i_riscv_arb_mem_rdata : '0;
        o_riscv_arb_ic_rvalid = (state_q == GNT_I) & i_riscv_arb_mem_ack;
        o_riscv_arb_dc_rvalid = (state_q == GNT_D) & ~we_q & i_riscv_arb_mem_ack;

        o_riscv_arb_ic_done   = (state_q == DONE) & ~own_dc_q;
        o_riscv_arb_dc_done   = (state_q == DONE) & own_dc_q;
        o_riscv_arb_dc_beat   = beat_q;

        // Stall follows the raw request, so it is masked while reset is held
        // to keep every output at 0 during reset.
        o_riscv_arb_ic_stall  = i_riscv_arb_ic_req & ~o_riscv_arb_ic_done & ~i_riscv_arb_rst;
        o_riscv_arb_dc_stall  = i_riscv_arb_dc_req & ~o_riscv_arb_dc_done & ~i_riscv_arb_rst;
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter (default parameters, fixed-priority build).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.

module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req, dc_we, mem_ack;
    logic [63:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic        ic_rvalid, dc_rvalid, ic_done, dc_done, ic_stall, dc_stall;
    logic        mem_req, mem_we;
    logic [63:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  dc_beat;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .BURST_LEN(4)) dut (
        .i_riscv_arb_clk      (clk),
        .i_riscv_arb_rst      (rst),
        .i_riscv_arb_ic_req   (ic_req),
        .i_riscv_arb_ic_addr  (ic_addr),
        .i_riscv_arb_dc_req   (dc_req),
        .i_riscv_arb_dc_we    (dc_we),
        .i_riscv_arb_dc_addr  (dc_addr),
        .i_riscv_arb_dc_wdata (dc_wdata),
        .o_riscv_arb_ic_rvalid(ic_rvalid),
        .o_riscv_arb_dc_rvalid(dc_rvalid),
        .o_riscv_arb_rdata    (rdata),
        .o_riscv_arb_ic_done  (ic_done),
        .o_riscv_arb_dc_done  (dc_done),
        .o_riscv_arb_dc_beat  (dc_beat),
        .o_riscv_arb_ic_stall (ic_stall),
        .o_riscv_arb_dc_stall (dc_stall),
        .o_riscv_arb_mem_req  (mem_req),
        .o_riscv_arb_mem_we   (mem_we),
        .o_riscv_arb_mem_addr (mem_addr),
        .o_riscv_arb_mem_wdata(mem_wdata),
        .i_riscv_arb_mem_ack  (mem_ack),
        .i_riscv_arb_mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks for a granted read beat with the given owner.
    task automatic chk_rd_beat(input string tag, input bit own_dc, input logic [63:0] addr,
                               input logic [63:0] data);
        chk({tag, "_req"},    64'(mem_req),   64'd1);
        chk({tag, "_we"},     64'(mem_we),    64'd0);
        chk({tag, "_addr"},   mem_addr,       addr);
        chk({tag, "_rdata"},  rdata,          data);
        chk({tag, "_icrv"},   64'(ic_rvalid), 64'(!own_dc));
        chk({tag, "_dcrv"},   64'(dc_rvalid), 64'(own_dc));
    endtask

    initial begin
        rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_memreq", 64'(mem_req), 64'd0);
        chk("rst_addr",   mem_addr,     64'd0);
        chk("rst_beat",   64'(dc_beat), 64'd0);
        chk("rst_done",   64'({ic_done, dc_done}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Icache refill alone at 0x1000, ack every cycle
        ic_req = 1; ic_addr = 64'h1000; mem_ack = 1; mem_rdata = 64'hD000;
        @(negedge clk);
        chk("ic_idle_req",   64'(mem_req),   64'd0);
        chk("ic_idle_rv",    64'(ic_rvalid), 64'd0);
        chk("ic_idle_stall", 64'(ic_stall),  64'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            mem_rdata = 64'hD000 + 64'(b);
            @(negedge clk);
            chk_rd_beat($sformatf("ic_b%0d", b), 1'b0, 64'h1000 + 64'(8 * b), 64'hD000 + 64'(b));
            chk($sformatf("ic_b%0d_stall", b), 64'(ic_stall), 64'd1);
            chk($sformatf("ic_b%0d_done", b),  64'(ic_done),  64'd0);
        end
        tick();
        @(negedge clk);
        chk("ic_done",       64'(ic_done),   64'd1);
        chk("ic_done_dc",    64'(dc_done),   64'd0);
        chk("ic_done_req",   64'(mem_req),   64'd0);
        chk("ic_done_stall", 64'(ic_stall),  64'd0);
        chk("ic_done_ackig", 64'(ic_rvalid), 64'd0);
        tick();
        ic_req = 0;
        @(negedge clk);
        chk("ic_after_done", 64'(ic_done), 64'd0);
        chk("ic_after_req",  64'(mem_req), 64'd0);
        chk("ic_after_rv",   64'(ic_rvalid), 64'd0);
        tick();
        mem_ack = 0;

        // Contention: dcache refill wins, icache follows
        ic_req = 1; ic_addr = 64'h1000; dc_req = 1; dc_we = 0; dc_addr = 64'h3000;
        mem_ack = 1; mem_rdata = 64'hE000;
        @(negedge clk);
        chk("ct_idle_req", 64'(mem_req), 64'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            mem_rdata = 64'hE000 + 64'(b);
            @(negedge clk);
            chk_rd_beat($sformatf("ct_dc_b%0d", b), 1'b1, 64'h3000 + 64'(8 * b), 64'hE000 + 64'(b));
            chk($sformatf("ct_dc_b%0d_beat", b),    64'(dc_beat),  64'(b));
            chk($sformatf("ct_dc_b%0d_icstall", b), 64'(ic_stall), 64'd1);
        end
        tick();
        @(negedge clk);
        chk("ct_dc_done",      64'(dc_done),  64'd1);
        chk("ct_ic_notdone",   64'(ic_done),  64'd0);
        chk("ct_done_icstall", 64'(ic_stall), 64'd1);
        chk("ct_done_dcstall", 64'(dc_stall), 64'd0);
        tick();
        dc_req = 0;
        @(negedge clk);
        chk("ct_gap_req",     64'(mem_req),  64'd0);
        chk("ct_gap_icstall", 64'(ic_stall), 64'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            mem_rdata = 64'hF000 + 64'(b);
            @(negedge clk);
            chk_rd_beat($sformatf("ct_ic_b%0d", b), 1'b0, 64'h1000 + 64'(8 * b), 64'hF000 + 64'(b));
            chk($sformatf("ct_ic_b%0d_stall", b), 64'(ic_stall), 64'd1);
        end
        tick();
        @(negedge clk);
        chk("ct_ic_done", 64'(ic_done), 64'd1);
        tick();
        ic_req = 0; mem_ack = 0;
        tick();

        // Dcache write-back at 0x2000, ack on alternate cycles
        dc_req = 1; dc_we = 1; dc_addr = 64'h2000; dc_wdata = 64'hA0;
        @(negedge clk);
        chk("wb_idle_req", 64'(mem_req), 64'd0);
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 2; a++) begin
                tick();
                mem_ack  = (a == 1);
                dc_wdata = 64'hA0 + 64'(b);
                @(negedge clk);
                chk($sformatf("wb_b%0d_%0d_req", b, a),   64'(mem_req),   64'd1);
                chk($sformatf("wb_b%0d_%0d_we", b, a),    64'(mem_we),    64'd1);
                chk($sformatf("wb_b%0d_%0d_addr", b, a),  mem_addr,       64'h2000 + 64'(8 * b));
                chk($sformatf("wb_b%0d_%0d_beat", b, a),  64'(dc_beat),   64'(b));
                chk($sformatf("wb_b%0d_%0d_wdata", b, a), mem_wdata,      64'hA0 + 64'(b));
                chk($sformatf("wb_b%0d_%0d_rv", b, a),    64'(dc_rvalid), 64'd0);
            end
        end
        tick();
        mem_ack = 0;
        @(negedge clk);
        chk("wb_done",    64'(dc_done), 64'd1);
        chk("wb_done_we", 64'(mem_we),  64'd0);
        tick();
        dc_req = 0; dc_we = 0;
        tick();

        // Reset mid-burst after beat 1
        ic_req = 1; ic_addr = 64'h4000; mem_ack = 1; mem_rdata = 64'h11;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("rs_beat2_addr", mem_addr, 64'h4010);
        #1 rst = 1'b1;
        #1;
        chk("rs_async_req",   64'(mem_req),   64'd0);
        chk("rs_async_addr",  mem_addr,       64'd0);
        chk("rs_async_beat",  64'(dc_beat),   64'd0);
        chk("rs_async_rv",    64'(ic_rvalid), 64'd0);
        chk("rs_async_rdata", rdata,          64'd0);
        chk("rs_async_stall", 64'(ic_stall),  64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_idle_req",  64'(mem_req), 64'd0);
        chk("rs_idle_done", 64'(ic_done), 64'd0);
        tick();
        @(negedge clk);
        chk("rs_restart_addr", mem_addr,     64'h4000);
        chk("rs_restart_beat", 64'(dc_beat), 64'd0);
        chk("rs_restart_done", 64'(ic_done), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; ic_req = 0; mem_ack = 0;
        tick();

        // Icache drops request after beat 0; burst still completes
        ic_req = 1; ic_addr = 64'h5000; mem_ack = 1; mem_rdata = 64'h50;
        tick();
        @(negedge clk);
        chk_rd_beat("dr_b0", 1'b0, 64'h5000, 64'h50);
        for (int b = 1; b < 4; b++) begin
            tick();
            ic_req = 0;
            mem_rdata = 64'h50 + 64'(b);
            @(negedge clk);
            chk_rd_beat($sformatf("dr_b%0d", b), 1'b0, 64'h5000 + 64'(8 * b), 64'h50 + 64'(b));
            chk($sformatf("dr_b%0d_stall", b), 64'(ic_stall), 64'd0);
        end
        tick();
        @(negedge clk);
        chk("dr_done", 64'(ic_done), 64'd1);
        tick();
        @(negedge clk);
        chk("dr_done_once", 64'(ic_done), 64'd0);
        chk("dr_idle_req",  64'(mem_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
